// File: rtl/pwm_modulator.sv
// PWM output stage for one filter channel: a one-deep sample buffer feeds a fixed-period
// PWM whose duty code is swapped in only at period boundaries, so the pin never glitches.
module pwm_modulator #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              pwm_out,
    output logic              period_start
);

    localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    // Period is 2**CNT_W-1 ticks, so the last count is all-ones minus one.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    function automatic logic [CNT_W-1:0] duty_code(input logic signed [DATA_W-1:0] sample);
        return {~sample[DATA_W-1], sample[DATA_W-2 -: CNT_W-1]};
    endfunction

    logic signed [DATA_W-1:0] w_sample;
    logic                     w_unused_lsbs;
    logic                     w_accept;
    logic                     w_first;
    logic                     w_tick;
    logic                     w_bnd;
    logic [PSC_W-1:0]         w_psc_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic [CNT_W-1:0]         w_duty_next;

    logic                     r_en_d;
    logic                     r_pend_vld;
    logic [CNT_W-1:0]         r_pend_duty;
    logic [CNT_W-1:0]         r_active;
    logic [CNT_W-1:0]         r_cnt;
    logic [PSC_W-1:0]         r_psc;

    assign w_sample      = s_data;
    assign w_unused_lsbs = ^w_sample[DATA_W-CNT_W-1:0];

    assign s_ready  = !r_pend_vld;
    assign w_accept = s_valid && s_ready;

    // A fresh period starts on the first enabled cycle as well as on the wrap tick.
    assign w_first = en && !r_en_d;
    assign w_tick  = en && (r_psc == PSC_LAST);
    assign w_bnd   = w_first || (w_tick && (r_cnt == CNT_LAST));

    always_comb begin
        w_psc_next  = '0;
        w_cnt_next  = '0;
        w_duty_next = (w_bnd && r_pend_vld) ? r_pend_duty : r_active;
        if (en && !w_first) begin
            w_psc_next = w_tick ? '0 : r_psc + 1'b1;
            if (w_bnd) begin
                w_cnt_next = '0;
            end else if (w_tick) begin
                w_cnt_next = r_cnt + 1'b1;
            end else begin
                w_cnt_next = r_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_d       <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_active     <= '0;
            r_cnt        <= '0;
            r_psc        <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            r_en_d       <= en;
            r_active     <= w_duty_next;
            r_cnt        <= w_cnt_next;
            r_psc        <= w_psc_next;
            pwm_out      <= en && (w_cnt_next < w_duty_next);
            period_start <= w_bnd;
            // Accept only happens with pending empty, so it never races the drain.
            if (w_accept) begin
                r_pend_vld <= 1'b1;
            end else if (w_bnd) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_duty <= duty_code(w_sample);
        end
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Bench for pwm_modulator (CNT_W=4): a PRESCALE=1 instance scored per period against a
// queue of accepted duties, plus a PRESCALE=3 instance checked with a directed sequence.
module tb_pwm_modulator;

    typedef struct { logic [15:0] sample; int high; } vec_t;
    typedef struct { int acc; int high; } sb_t;

    logic        clk, rst;
    logic        en1, s_valid1, s_ready1, pwm_out1, period_start1;
    logic        en3, s_valid3, s_ready3, pwm_out3, period_start3;
    logic [15:0] s_data1, s_data3;

    int   checks = 0, failures = 0, cyc = 0;
    int   cur_high = 0, last_high = 0, n_applied = 0, last_bnd = 0;
    int   pos = 0, hi = 0, shape_bad = 0;
    bit   have_prev = 0, mon_en = 0;
    sb_t  sb_q[$];
    vec_t vec[7];

    pwm_modulator #(.DATA_W(16), .CNT_W(4), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .pwm_out(pwm_out1), .period_start(period_start1));

    pwm_modulator #(.DATA_W(16), .CNT_W(4), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .s_data(s_data3), .s_valid(s_valid3),
        .s_ready(s_ready3), .pwm_out(pwm_out3), .period_start(period_start3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-period scoreboard: a duty accepted before a boundary becomes the expectation from it on.
    initial forever begin
        @(negedge clk);
        if (!rst) cur_high = 0;
        if (!mon_en) begin
            have_prev = 0;
        end else begin
            if (period_start1) begin
                if (have_prev) begin
                    check("period_len", pos, 15);
                    check("period_shape_badclks", shape_bad, 0);
                    last_high = hi;
                end
                if (sb_q.size() > 0 && sb_q[0].acc < cyc) begin
                    cur_high = sb_q[0].high;
                    sb_q.delete(0);
                    n_applied++;
                end
                pos = 0; hi = 0; shape_bad = 0; have_prev = 1; last_bnd = cyc;
            end
            if (have_prev) begin
                if (pwm_out1 !== (pos < cur_high)) shape_bad++;
                if (pwm_out1) hi++;
                pos++;
            end
        end
    end

    task automatic send1(input logic [15:0] d, input int high, output int acc);
        acc = -1;
        @(negedge clk);
        s_data1 = d; s_valid1 = 1'b1;
        for (int t = 0; t < 200 && acc < 0; t++) begin
            #1;
            if (s_ready1) begin
                @(posedge clk); #1;
                acc = cyc;
                sb_q.push_back('{acc, high});
            end else begin
                @(negedge clk);
            end
        end
        if (acc < 0) check("send_timeout", 0, 1);
        @(negedge clk);
        s_valid1 = 1'b0;
    endtask

    task automatic wait_pstart1(input int n);
        int seen;
        seen = 0;
        for (int t = 0; t < 2000 && seen < n; t++) begin
            @(negedge clk);
            if (period_start1) seen++;
        end
        if (seen < n) check("pstart_timeout", seen, n);
    endtask

    task automatic wait_applied(input int tgt);
        for (int t = 0; t < 2000 && n_applied < tgt; t++) begin
            @(negedge clk); #1;
        end
        if (n_applied < tgt) check("apply_timeout", n_applied, tgt);
    endtask

    task automatic en_gap(input bit do_send, input logic [15:0] d, input int exp);
        int acc, tgt;
        wait_pstart1(1);
        repeat (2) @(negedge clk);
        mon_en = 0; en1 = 1'b0;
        @(negedge clk);
        check("en_off_pwm", int'(pwm_out1), 0);
        check("en_off_pstart", int'(period_start1), 0);
        tgt = n_applied + 1;
        if (do_send) send1(d, exp, acc);
        repeat (8) @(negedge clk);
        check("en_off_hold", int'(pwm_out1), 0);
        mon_en = 1; en1 = 1'b1;
        if (do_send) wait_applied(tgt);
        wait_pstart1(2); #1;
        check("en_resume_high", last_high, exp);
    endtask

    initial begin
        int acc, acc_b, tgt, found;
        int pos3, hi3, bad3, ps3;
        vec[0] = '{16'h0000, 8};
        vec[1] = '{16'h7FFF, 15};
        vec[2] = '{16'h8000, 0};
        vec[3] = '{16'h4000, 12};
        vec[4] = '{16'hC000, 4};
        vec[5] = '{16'h1FFF, 9};
        vec[6] = '{16'hFFFF, 7};

        rst = 1'b0; en1 = 1'b1; en3 = 1'b0;
        s_valid1 = 1'b0; s_valid3 = 1'b0; s_data1 = '0; s_data3 = '0;
        repeat (2) @(negedge clk);
        check("rst_pwm1", int'(pwm_out1), 0);
        check("rst_pstart1", int'(period_start1), 0);
        check("rst_ready1", int'(s_ready1), 1);
        check("rst_pwm3", int'(pwm_out3), 0);
        check("rst_ready3", int'(s_ready3), 1);
        rst = 1'b1; mon_en = 1;

        // No sample yet: idle low with a period_start every 15 clk.
        wait_pstart1(4); #1;
        check("idle_high", last_high, 0);

        for (int i = 0; i < 7; i++) begin
            tgt = n_applied + 1;
            send1(vec[i].sample, vec[i].high, acc);
            wait_applied(tgt);
            wait_pstart1(1); #1;
            check($sformatf("vec%0d_high", i), last_high, vec[i].high);
        end

        // Two samples mid-period: second waits for the boundary, lands one clk after it.
        tgt = n_applied + 2;
        wait_pstart1(1);
        repeat (4) @(negedge clk);
        send1(16'h4000, 12, acc);
        #1;
        check("b2b_ready_low", int'(s_ready1), 0);
        send1(16'hC000, 4, acc_b);
        check("b2b_second_accept_cyc", acc_b, last_bnd + 1);
        wait_applied(tgt);
        wait_pstart1(1); #1;
        check("b2b_final_high", last_high, 4);

        en_gap(1'b0, 16'h0000, 4);
        en_gap(1'b1, 16'h8000, 0);

        // Async reset mid-period with a sample pending.
        tgt = n_applied + 1;
        send1(16'h7FFF, 15, acc);
        wait_applied(tgt);
        wait_pstart1(1);
        repeat (5) @(negedge clk);
        send1(16'h0000, 8, acc);
        check("pre_rst_ready", int'(s_ready1), 0);
        check("pre_rst_pwm", int'(pwm_out1), 1);
        mon_en = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_out1), 0);
        check("async_rst_ready", int'(s_ready1), 1);
        check("async_rst_pstart", int'(period_start1), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1; mon_en = 1;
        wait_pstart1(4); #1;
        check("post_rst_high", last_high, 0);

        // PRESCALE=3: sample loaded while idle, then enabled.
        @(negedge clk);
        s_data3 = 16'h0000; s_valid3 = 1'b1;
        #1;
        check("p3_ready", int'(s_ready3), 1);
        @(negedge clk);
        s_valid3 = 1'b0; en3 = 1'b1;
        found = 0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            @(negedge clk);
            if (period_start3) found = 1;
        end
        check("p3_first_pstart", found, 1);
        for (int k = 0; k < 2; k++) begin
            pos3 = 0; hi3 = 0; bad3 = 0; ps3 = 0;
            do begin
                if (pwm_out3 !== (pos3 < 24)) bad3++;
                if (pwm_out3) hi3++;
                if (period_start3) ps3++;
                pos3++;
                @(negedge clk);
            end while (!period_start3 && pos3 < 100);
            check($sformatf("p3_len%0d", k), pos3, 45);
            check($sformatf("p3_high%0d", k), hi3, 24);
            check($sformatf("p3_shape%0d", k), bad3, 0);
            check($sformatf("p3_pstart_clks%0d", k), ps3, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
